ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: it sends one command byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") from the FPGA to the attached mouse or keyboard over the shared open-drain PS2C/PS2D lines. It performs the request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device ACK. It sits next to the existing PS/2 receive path in Top. The simulated mouse model acts as the device end in the system bench.

---
 rtl/ps2_host_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter. Performs the
// request-to-send, shifts a byte out on device clocks and checks the ACK.
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic [7:0] data_in,
  input  logic       wr,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);

  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] ACK_LOAD = FW'(FILTER_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_REQ       = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  logic [1:0]    c_sync_q, d_sync_q;
  logic          filt_q, fall_q;
  logic [FW-1:0] flt_cnt_q;
  logic          c_s, d_s;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [8:0]    shift_q, shift_d;
  logic          dlow_q, dlow_d;
  logic          ack_wait_q, ack_wait_d;
  logic [FW-1:0] ack_cnt_q, ack_cnt_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          timeout_q, timeout_d;
  logic          busy_q, busy_d;
  logic          c_oe_q, c_oe_d;
  logic          d_oe_q, d_oe_d;
  logic          watched, expire;

  assign c_s = c_sync_q[1];
  assign d_s = d_sync_q[1];

  // Filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      c_sync_q  <= 2'b11;
      d_sync_q  <= 2'b11;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_in};
      d_sync_q <= {d_sync_q[0], ps2d_in};
      fall_q   <= 1'b0;
      if (c_s == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        filt_q    <= c_s;
        flt_cnt_q <= '0;
        fall_q    <= filt_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      dlow_q     <= 1'b0;
      ack_wait_q <= 1'b0;
      ack_cnt_q  <= '0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      c_oe_q     <= 1'b0;
      d_oe_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      dlow_q     <= dlow_d;
      ack_wait_q <= ack_wait_d;
      ack_cnt_q  <= ack_cnt_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      c_oe_q     <= c_oe_d;
      d_oe_q     <= d_oe_d;
    end
  end

  assign watched = (state_q == S_REQ) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign expire  = ~fall_q && (cnt_q <= CW'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    dlow_d     = dlow_q;
    ack_wait_d = ack_wait_q;
    ack_cnt_d  = ack_cnt_q;
    nack_d     = nack_q;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    timeout_d  = 1'b0;

    if (watched) begin
      cnt_d = fall_q ? TO_LOAD : (cnt_q - CW'(1));
    end

    case (state_q)
      S_IDLE: begin
        if (wr) begin
          shift_d = {~^data_in, data_in};
          cnt_d   = INH_LOAD;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d    = S_REQ;
        cnt_d      = TO_LOAD;
        idx_d      = '0;
        dlow_d     = 1'b1;
        ack_wait_d = 1'b0;
      end
      S_REQ: begin
        // Falls 1..9 place D0..D7 and parity; the 10th releases for the stop bit.
        if (fall_q) begin
          if (idx_q == 4'd9) begin
            dlow_d  = 1'b0;
            state_d = S_ACK;
          end else begin
            dlow_d = ~shift_q[idx_q];
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fall_q) begin
          ack_wait_d = 1'b1;
          ack_cnt_d  = ACK_LOAD;
        end else if (ack_wait_q) begin
          if (ack_cnt_q <= FW'(1)) begin
            nack_d     = d_s;
            ack_wait_d = 1'b0;
            state_d    = S_WAIT_IDLE;
          end else begin
            ack_cnt_d = ack_cnt_q - FW'(1);
          end
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q && d_s) begin
          state_d   = S_IDLE;
          done_d    = ~nack_q;
          ack_err_d = nack_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (watched && expire) begin
      state_d    = S_IDLE;
      dlow_d     = 1'b0;
      ack_wait_d = 1'b0;
      done_d     = 1'b0;
      ack_err_d  = 1'b0;
      timeout_d  = 1'b1;
    end
  end

  // Pin enables and status are registered from the next state to keep the pads glitch-free.
  always_comb begin
    c_oe_d = (state_d == S_INHIBIT) || (state_d == S_START);
    d_oe_d = (state_d == S_START) || ((state_d == S_REQ) && dlow_d);
    busy_d = (state_d != S_IDLE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign timeout = timeout_q;
  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven and randomized check of ps2_host_tx against a
// PS/2 device model on the open-drain bus.
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH = 1000;
  localparam int TO  = 3000;
  localparam int FL  = 8;
  localparam int HI  = 30;
  localparam int LO  = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, done, ack_err, timeout, ps2c_oe, ps2d_oe;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c_line, ps2d_line;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_to     = 0;

  assign ps2c_line = ~(ps2c_oe | dev_c_low);
  assign ps2d_line = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .CLK50MHZ(clk),
    .RST(rst),
    .data_in(data_in),
    .wr(wr),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout(timeout),
    .ps2c_in(ps2c_line),
    .ps2d_in(ps2d_line),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe)
  );

  always #5 clk = ~clk;

  // Pulse cycle counters: a pulse longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    if (done === 1'b1)    n_done++;
    if (ack_err === 1'b1) n_err++;
    if (timeout === 1'b1) n_to++;
  end

  typedef struct {
    logic [7:0] d;
    bit         ack;
    int         glitch_k;
    int         wr2_k;
    logic [7:0] d2;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line values the device sees before each of its 11 clock falls.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int v, ones, b;
    v    = d;
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      b = (v / (1 << i)) % 2;
      ones += b;
      f[i+1] = (b != 0);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_wr(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    wr      = 1'b1;
    @(negedge clk);
    wr      = 1'b0;
    data_in = 8'h00;
  endtask

  task automatic run_tx(input string tag, input logic [7:0] d, input bit ack, input int glitch_k,
                        input int wr2_k, input logic [7:0] d2, input int rst_k);
    logic [10:0] bits;
    logic        pre, last, dbefore;
    int          n, b_done, b_err, b_to;
    bit          aborted;
    b_done  = n_done;
    b_err   = n_err;
    b_to    = n_to;
    bits    = '1;
    aborted = 1'b0;
    pre     = 1'b0;
    last    = 1'b0;

    send_wr(d);
    check({tag, "_busy_oe_rise"}, {30'd0, busy, ps2c_oe}, 32'h3);
    n = 0;
    while (ps2c_oe === 1'b1 && n < INH + 50) begin
      pre  = last;
      last = ps2d_oe;
      n++;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, n, INH + 1);
    check({tag, "_start_lead"}, {30'd0, pre, last}, 32'h1);

    for (int k = 0; k < 11; k++) begin
      if (k == glitch_k) begin
        repeat (10) @(negedge clk);
        dbefore   = ps2d_oe;
        dev_c_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (16) @(negedge clk);
        check({tag, "_glitch_no_adv"}, {31'd0, ps2d_oe}, {31'd0, dbefore});
      end
      if (k == wr2_k) send_wr(d2);
      repeat (HI) @(negedge clk);
      bits[k]   = ps2d_line;
      dev_c_low = 1'b1;
      if (k == 10) dev_d_low = ack;
      if (k == rst_k) begin
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({tag, "_rst_state"}, {29'd0, busy, ps2c_oe, ps2d_oe}, 32'h0);
        dev_c_low = 1'b0;
        aborted   = 1'b1;
        break;
      end
      repeat (LO) @(negedge clk);
      dev_c_low = 1'b0;
    end

    if (!aborted) begin
      repeat (5) @(negedge clk);
      dev_d_low = 1'b0;
      repeat (40) @(negedge clk);
      check({tag, "_frame_bits"}, {21'd0, bits}, {21'd0, model_frame(d)});
      check({tag, "_done_cnt"}, n_done - b_done, ack ? 1 : 0);
      check({tag, "_ackerr_cnt"}, n_err - b_err, ack ? 0 : 1);
      check({tag, "_timeout_cnt"}, n_to - b_to, 0);
      check({tag, "_idle"}, {29'd0, busy, ps2c_oe, ps2d_oe}, 32'h0);
    end else begin
      repeat (100) @(negedge clk);
      check({tag, "_no_pulses"}, (n_done - b_done) + (n_err - b_err) + (n_to - b_to), 0);
      check({tag, "_idle"}, {29'd0, busy, ps2c_oe, ps2d_oe}, 32'h0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n, b_to;
    logic [7:0] rd;
    bit         ra;

    vecs[0] = '{d: 8'hF4, ack: 1'b1, glitch_k: -1, wr2_k: -1, d2: 8'h00};
    vecs[1] = '{d: 8'hFF, ack: 1'b0, glitch_k: -1, wr2_k: -1, d2: 8'h00};
    vecs[2] = '{d: 8'hAA, ack: 1'b1, glitch_k: -1, wr2_k: 4,  d2: 8'h55};
    vecs[3] = '{d: 8'h3C, ack: 1'b1, glitch_k: 3,  wr2_k: -1, d2: 8'h00};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, busy, done, ack_err, timeout, ps2c_oe, ps2d_oe}, 32'h0);

    // wr coincident with reset must be dropped
    data_in = 8'h12;
    wr      = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    wr      = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    check("wr_during_rst", {30'd0, busy, ps2c_oe}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      run_tx($sformatf("vec%0d", i), vecs[i].d, vecs[i].ack, vecs[i].glitch_k,
             vecs[i].wr2_k, vecs[i].d2, -1);
    end

    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      run_tx($sformatf("rand%0d_%02h", i, rd), rd, ra, -1, -1, 8'h00, -1);
    end

    // Device never clocks: watchdog fires TO cycles after clock release.
    b_to = n_to;
    send_wr(8'hED);
    n = 0;
    while (ps2c_oe === 1'b1 && n < INH + 50) begin
      n++;
      @(negedge clk);
    end
    n = 0;
    while (timeout !== 1'b1 && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TO);
    check("timeout_state", {29'd0, busy, ps2c_oe, ps2d_oe}, 32'h0);
    repeat (5) @(negedge clk);
    check("timeout_cnt", n_to - b_to, 1);

    run_tx("rst_mid", 8'hF4, 1'b1, -1, -1, 8'h00, 4);
    run_tx("after_rst", 8'hF4, 1'b1, -1, -1, 8'h00, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
